signal_head_driver: RTL and testbench

Lamp-side decoder for the intersection phase controller. Samples the controller's 3-bit phase code every cycle and drives the car signal head (red/yellow/green) and the pedestrian head (red/green), generating the blink cadence locally. Monitors the phase stream for invalid codes and, optionally, illegal phase transitions. On a fault it latches a safe flashing-yellow pattern until reset.

---
 rtl/traffic_pkg.sv | 38 +++
 rtl/signal_head_driver_if.sv | 21 ++
 rtl/blink_gen.sv | 42 ++++
 rtl/signal_head_driver.sv | 105 ++++++++++
 tb/tb_signal_head_driver.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encodings, lamp bit indices and the legal-transition rule for the
// intersection controller and its signal heads.
package traffic_pkg;

   typedef enum logic [2:0] {
      PhYellow      = 3'd0,
      PhYellowBlink = 3'd1,
      PhGreen       = 3'd2,
      PhGreenBlink  = 3'd3,
      PhRed         = 3'd4,
      PhRedYellow   = 3'd5,
      PhCrosswalk   = 3'd6,
      PhInvalid     = 3'd7
   } phase_e;

   localparam int unsigned LampCarRed    = 0;
   localparam int unsigned LampCarYellow = 1;
   localparam int unsigned LampCarGreen  = 2;
   localparam int unsigned LampPedRed    = 3;
   localparam int unsigned LampPedGreen  = 4;
   localparam int unsigned NumLamps      = 5;

   // Any phase may fall back to flashing yellow; otherwise only the ring order is allowed.
   function automatic logic legal_transition(input logic [2:0] from_ph, input logic [2:0] to_ph);
      logic ok;
      ok = (to_ph == PhYellowBlink);
      if (from_ph == PhYellowBlink && to_ph == PhGreen)     ok = 1'b1;
      if (from_ph == PhGreen       && to_ph == PhGreenBlink) ok = 1'b1;
      if (from_ph == PhGreenBlink  && to_ph == PhYellow)    ok = 1'b1;
      if (from_ph == PhYellow      && to_ph == PhRed)       ok = 1'b1;
      if (from_ph == PhRed         && to_ph == PhRedYellow) ok = 1'b1;
      if (from_ph == PhRed         && to_ph == PhCrosswalk) ok = 1'b1;
      if (from_ph == PhCrosswalk   && to_ph == PhRedYellow) ok = 1'b1;
      if (from_ph == PhRedYellow   && to_ph == PhGreen)     ok = 1'b1;
      return ok;
   endfunction

endpackage

// File: rtl/signal_head_driver_if.sv
// Phase input and lamp/fault outputs between the phase controller and a signal head.
interface signal_head_driver_if;
   logic [2:0] phase;
   logic       car_red;
   logic       car_yellow;
   logic       car_green;
   logic       ped_red;
   logic       ped_green;
   logic       fault;
   logic [2:0] fault_phase;

   modport master (
      output phase,
      input  car_red, car_yellow, car_green, ped_red, ped_green, fault, fault_phase
   );

   modport slave (
      input  phase,
      output car_red, car_yellow, car_green, ped_red, ped_green, fault, fault_phase
   );
endinterface

// File: rtl/blink_gen.sv
// Blink cadence generator: BLINK_HALF cycles lit, BLINK_HALF dark, restartable lit.
module blink_gen #(
   parameter int unsigned BLINK_HALF = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_chg,
   input  logic i_fault_new,
   input  logic i_free_run,
   output logic o_blink_nx
);

   localparam logic [7:0] HalfM1 = 8'(BLINK_HALF - 1);

   logic [7:0] r_blink_cnt;
   logic [7:0] w_cnt_nx;
   logic       r_blink_on;

   // A phase change restarts the cadence unless free-running; a new fault always does.
   always_comb begin
      w_cnt_nx   = r_blink_cnt + 8'd1;
      o_blink_nx = r_blink_on;
      if (i_fault_new || (i_chg && !i_free_run)) begin
         w_cnt_nx   = '0;
         o_blink_nx = 1'b1;
      end else if (r_blink_cnt == HalfM1) begin
         w_cnt_nx   = '0;
         o_blink_nx = !r_blink_on;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else begin
         r_blink_cnt <= w_cnt_nx;
         r_blink_on  <= o_blink_nx;
      end
   end

endmodule

// File: rtl/signal_head_driver.sv
// Decodes the controller phase code into registered car/pedestrian lamps with a latched
// flashing-yellow fault mode. Define SIGNAL_HEAD_TRANSITION_CHECK_EN to also fault on illegal moves.
module signal_head_driver
   import traffic_pkg::*;
#(
   parameter int unsigned BLINK_HALF = 2
) (
   input logic                 clk,
   input logic                 reset,
   signal_head_driver_if.slave bus
);

   logic [2:0]          r_phase_q;
   logic                r_fault;
   logic [2:0]          r_fault_phase;
   logic [NumLamps-1:0] r_lamps;
   logic [NumLamps-1:0] w_lamps;
   logic                w_chg;
   logic                w_illegal;
   logic                w_fault_new;
   logic                w_blink_nx;

   assign w_chg = (bus.phase != r_phase_q);

`ifdef SIGNAL_HEAD_TRANSITION_CHECK_EN
   assign w_illegal = w_chg && !legal_transition(r_phase_q, bus.phase);
`else
   assign w_illegal = 1'b0;
`endif

   assign w_fault_new = !r_fault && ((bus.phase == PhInvalid) || w_illegal);

   blink_gen #(
      .BLINK_HALF (BLINK_HALF)
   ) u_blink_gen (
      .clk         (clk),
      .reset       (reset),
      .i_chg       (w_chg),
      .i_fault_new (w_fault_new),
      .i_free_run  (r_fault),
      .o_blink_nx  (w_blink_nx)
   );

   always_comb begin
      w_lamps = '0;
      if (r_fault || w_fault_new) begin
         w_lamps[LampCarYellow] = w_blink_nx;
      end else begin
         case (bus.phase)
            PhYellow: begin
               w_lamps[LampCarYellow] = 1'b1;
               w_lamps[LampPedRed]    = 1'b1;
            end
            PhYellowBlink: w_lamps[LampCarYellow] = w_blink_nx;
            PhGreen: begin
               w_lamps[LampCarGreen] = 1'b1;
               w_lamps[LampPedRed]   = 1'b1;
            end
            PhGreenBlink: begin
               w_lamps[LampCarGreen] = w_blink_nx;
               w_lamps[LampPedRed]   = 1'b1;
            end
            PhRed: begin
               w_lamps[LampCarRed] = 1'b1;
               w_lamps[LampPedRed] = 1'b1;
            end
            PhRedYellow: begin
               w_lamps[LampCarRed]    = 1'b1;
               w_lamps[LampCarYellow] = 1'b1;
               w_lamps[LampPedRed]    = 1'b1;
            end
            PhCrosswalk: begin
               w_lamps[LampCarRed]   = 1'b1;
               w_lamps[LampPedGreen] = 1'b1;
            end
            default: w_lamps = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase_q     <= PhYellowBlink;
         r_fault       <= 1'b0;
         r_fault_phase <= '0;
         r_lamps       <= '0;
      end else begin
         r_phase_q <= bus.phase;
         r_lamps   <= w_lamps;
         if (w_fault_new) begin
            r_fault       <= 1'b1;
            r_fault_phase <= bus.phase;
         end
      end
   end

   assign bus.car_red     = r_lamps[LampCarRed];
   assign bus.car_yellow  = r_lamps[LampCarYellow];
   assign bus.car_green   = r_lamps[LampCarGreen];
   assign bus.ped_red     = r_lamps[LampPedRed];
   assign bus.ped_green   = r_lamps[LampPedGreen];
   assign bus.fault       = r_fault;
   assign bus.fault_phase = r_fault_phase;

endmodule

// File: tb/tb_signal_head_driver.sv
// Scoreboard bench for signal_head_driver: a reference model queues the expected lamps and
// fault state for each driven phase; they are popped and compared one cycle later.
module tb_signal_head_driver;

   localparam int unsigned Half = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   signal_head_driver_if bus_if ();

   signal_head_driver #(
      .BLINK_HALF (Half)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   // lamps = {car_red, car_yellow, car_green, ped_red, ped_green}
   typedef struct packed {
      logic [4:0] lamps;
      logic       fault;
      logic [2:0] fph;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   int         m_k;
   logic [2:0] m_prev;
   logic       m_fault;
   logic [2:0] m_fph;

   task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] lamp_tbl(input logic [2:0] ph, input logic lit);
      case (ph)
         3'd0:    return 5'b01010;
         3'd1:    return {1'b0, lit, 3'b000};
         3'd2:    return 5'b00110;
         3'd3:    return {2'b00, lit, 2'b10};
         3'd4:    return 5'b10010;
         3'd5:    return 5'b11010;
         3'd6:    return 5'b10001;
         default: return 5'b00000;
      endcase
   endfunction

   function automatic bit legal_tb(input logic [2:0] a, input logic [2:0] b);
      return (b == 3'd1) || (a == 3'd1 && b == 3'd2) || (a == 3'd2 && b == 3'd3) ||
             (a == 3'd3 && b == 3'd0) || (a == 3'd0 && b == 3'd4) || (a == 3'd4 && b == 3'd5) ||
             (a == 3'd4 && b == 3'd6) || (a == 3'd6 && b == 3'd5) || (a == 3'd5 && b == 3'd2);
   endfunction

   // m_k counts output cycles since the blink cadence last restarted lit.
   task automatic model_push(input logic [2:0] ph);
      exp_t e;
      bit   chg, bad, lit;
      chg = (ph != m_prev);
      bad = (ph == 3'd7);
`ifdef SIGNAL_HEAD_TRANSITION_CHECK_EN
      if (chg && !legal_tb(m_prev, ph)) bad = 1'b1;
`endif
      if (!m_fault && bad) begin
         m_fault = 1'b1;
         m_fph   = ph;
         m_k     = 0;
      end else if (!m_fault && chg) begin
         m_k = 0;
      end else begin
         m_k++;
      end
      lit    = ((m_k / Half) % 2) == 0;
      m_prev = ph;
      e.lamps = m_fault ? {1'b0, lit, 3'b000} : lamp_tbl(ph, lit);
      e.fault = m_fault;
      e.fph   = m_fph;
      sb_q.push_back(e);
   endtask

   function automatic logic [4:0] dut_lamps();
      return {bus_if.car_red, bus_if.car_yellow, bus_if.car_green, bus_if.ped_red,
              bus_if.ped_green};
   endfunction

   task automatic step(input logic [2:0] ph, input string tag);
      exp_t e;
      bus_if.phase = ph;
      model_push(ph);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_val({tag, "_lamps"}, {3'b0, dut_lamps()}, {3'b0, e.lamps});
      check_val({tag, "_fault"}, {7'b0, bus_if.fault}, {7'b0, e.fault});
      check_val({tag, "_fph"}, {5'b0, bus_if.fault_phase}, {5'b0, e.fph});
      check_val({tag, "_inv"},
                {5'b0, bus_if.car_green & bus_if.ped_green, bus_if.ped_red & bus_if.ped_green,
                 bus_if.car_green & bus_if.car_red}, 8'h00);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      m_k     = 0;
      m_prev  = 3'd1;
      m_fault = 1'b0;
      m_fph   = 3'd0;
      check_val({tag, "_lamps"}, {3'b0, dut_lamps()}, 8'h00);
      check_val({tag, "_fault"}, {7'b0, bus_if.fault}, 8'h00);
      check_val({tag, "_fph"}, {5'b0, bus_if.fault_phase}, 8'h00);
   endtask

   initial begin
      logic [7:0] pat;
      logic [2:0] ring[8];
      reset        = 1'b1;
      bus_if.phase = 3'd1;
      repeat (2) @(posedge clk);
      #1;
      do_reset("reset0");

      for (int i = 0; i < 10; i++) step(3'd2, "green");

      pat = '0;
      for (int i = 0; i < 8; i++) begin
         step(3'd3, "gblink");
         pat = {pat[6:0], bus_if.car_green};
      end
      check_val("gblink_pattern", pat, 8'b11001100);

      ring = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd6, 3'd5, 3'd2};
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 3; j++) step(ring[i], "ring");

      step(3'd4, "skip24");
`ifdef SIGNAL_HEAD_TRANSITION_CHECK_EN
      check_val("skip24_fault", {7'b0, bus_if.fault}, 8'h01);
      check_val("skip24_fph", {5'b0, bus_if.fault_phase}, 8'h04);
`else
      check_val("skip24_red", {6'b0, bus_if.car_red, bus_if.fault}, 8'h02);
`endif
      for (int i = 0; i < 5; i++) step(3'd4, "skip24_hold");
      do_reset("reset1");

      step(3'd4, "pre7");
      step(3'd7, "inv7");
      check_val("inv7_flag", {4'b0, bus_if.fault, bus_if.fault_phase}, 8'h0f);
      for (int i = 0; i < 8; i++) step(3'd4, "fault_hold");
      do_reset("reset2");

      step(3'd2, "pre_gb");
      for (int i = 0; i < 3; i++) step(3'd3, "gb_dark");
      check_val("gb_dark_cg", {7'b0, bus_if.car_green}, 8'h00);
      do_reset("reset_mid");
      step(3'd3, "post_reset");
      check_val("post_reset_cg", {7'b0, bus_if.car_green}, 8'h01);

      do_reset("reset3");
      for (int i = 0; i < 40; i++) step(3'($urandom_range(0, 6)), "rand");
      for (int i = 0; i < 6; i++) step(3'($urandom_range(0, 7)), "rand_f");
      do_reset("reset4");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
